// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - register map and defaults shared by the switch port
package switch_pkg;

  typedef enum logic [1:0] {
    SW_ADDR_LEVEL = 2'b00,
    SW_ADDR_RISE  = 2'b01,
    SW_ADDR_FALL  = 2'b10,
    SW_ADDR_MASK  = 2'b11
  } sw_addr_e;

  localparam int SW_DEBOUNCE_DEFAULT = 20000;
  localparam int SW_WIDTH_DEFAULT    = 16;
  localparam int SW_SYNC_DEFAULT     = 2;

  // Counter must be able to hold DEBOUNCE_CYCLES-1; sized from DEBOUNCE_CYCLES+1
  // so that DEBOUNCE_CYCLES=1 still yields a 1-bit counter.
  function automatic int sw_cnt_width(input int debounce_cycles);
    return $clog2(debounce_cycles + 1);
  endfunction

endpackage

// File: rtl/switch_debounce_ch.sv
// rtl/switch_debounce_ch.sv - one channel: synchroniser, debounce counter, edge pulses
module switch_debounce_ch
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT,
  parameter int SYNC_STAGES     = SW_SYNC_DEFAULT
) (
  input  logic switclk,
  input  logic switrst,
  input  logic pin,
  output logic stable,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int CW = sw_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   sync;

  assign sync   = sync_q[SYNC_STAGES-1];
  assign stable = stable_q;

  // Shift the raw pin through the synchroniser chain, bit 0 first.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin};
  end

  // Count consecutive mismatching cycles; accept the new level on the last one.
  // The edge pulses fire on the same edge that updates stable.
  always_comb begin
    cnt_d      = cnt_q;
    stable_d   = stable_q;
    rise_pulse = 1'b0;
    fall_pulse = 1'b0;
    if (sync == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d      = '0;
      stable_d   = sync;
      rise_pulse = sync;
      fall_pulse = ~sync;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Channel state; reset discards any debounce in progress.
  always_ff @(posedge switclk or posedge switrst) begin
    if (switrst) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

endmodule

// File: rtl/switch_port_debounced.sv
// rtl/switch_port_debounced.sv - memory-mapped debounced switch port with sticky flags and irq
module switch_port_debounced
  import switch_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH_DEFAULT,
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT,
  parameter int SYNC_STAGES     = SW_SYNC_DEFAULT
) (
  input  logic             switclk,
  input  logic             switrst,
  input  logic             switcs,
  input  logic             switread,
  input  logic             switwrite,
  input  logic [1:0]       switaddr,
  input  logic [WIDTH-1:0] switch_din,
  input  logic [WIDTH-1:0] switch_rdata,
  output logic [WIDTH-1:0] switch_wdata,
  output logic             switch_irq
);

  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] rise_ev, fall_ev;

  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             irq_q, irq_d;

  logic             rd_en, wr_en;
  logic [WIDTH-1:0] rd_mux;
  logic [WIDTH-1:0] clr_rise, clr_fall;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    switch_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_ch (
      .switclk    (switclk),
      .switrst    (switrst),
      .pin        (switch_rdata[g]),
      .stable     (level[g]),
      .rise_pulse (rise_ev[g]),
      .fall_pulse (fall_ev[g])
    );
  end

  assign rd_en = switcs && switread;
  assign wr_en = switcs && switwrite && (switaddr == SW_ADDR_MASK);

  // Register read mux; always reflects the state before the current edge.
  always_comb begin
    rd_mux = '0;
    case (switaddr)
      SW_ADDR_LEVEL: rd_mux = level;
      SW_ADDR_RISE:  rd_mux = rise_q;
      SW_ADDR_FALL:  rd_mux = fall_q;
      SW_ADDR_MASK:  rd_mux = mask_q;
      default:       rd_mux = '0;
    endcase
  end

  // Next-state for flags, mask, read data and irq; a new edge beats a clearing read.
  always_comb begin
    clr_rise = (rd_en && switaddr == SW_ADDR_RISE) ? rise_q : '0;
    clr_fall = (rd_en && switaddr == SW_ADDR_FALL) ? fall_q : '0;
    rise_d   = (rise_q & ~clr_rise) | rise_ev;
    fall_d   = (fall_q & ~clr_fall) | fall_ev;
    mask_d   = wr_en ? switch_din : mask_q;
    wdata_d  = rd_en ? rd_mux : wdata_q;
    irq_d    = |((rise_q | fall_q) & mask_q);
  end

  // CPU-visible state.
  always_ff @(posedge switclk or posedge switrst) begin
    if (switrst) begin
      rise_q  <= '0;
      fall_q  <= '0;
      mask_q  <= '0;
      wdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
      irq_q   <= irq_d;
    end
  end

  assign switch_wdata = wdata_q;
  assign switch_irq   = irq_q;

endmodule

// File: tb/tb_switch_port_debounced.sv
// tb/tb_switch_port_debounced.sv - directed and random checks against a reference model
module tb_switch_port_debounced;

  localparam int W  = 16;
  localparam int DC = 4;
  localparam int SS = 2;

  logic         switclk = 1'b0;
  logic         switrst;
  logic         switcs;
  logic         switread;
  logic         switwrite;
  logic [1:0]   switaddr;
  logic [W-1:0] switch_din;
  logic [W-1:0] switch_rdata;
  logic [W-1:0] switch_wdata;
  logic         switch_irq;

  switch_port_debounced #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DC),
    .SYNC_STAGES     (SS)
  ) dut (
    .switclk      (switclk),
    .switrst      (switrst),
    .switcs       (switcs),
    .switread     (switread),
    .switwrite    (switwrite),
    .switaddr     (switaddr),
    .switch_din   (switch_din),
    .switch_rdata (switch_rdata),
    .switch_wdata (switch_wdata),
    .switch_irq   (switch_irq)
  );

  always #5 switclk = ~switclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stimulus for the next edge.
  logic         d_rst  = 1'b0;
  logic         d_cs   = 1'b0;
  logic         d_rd   = 1'b0;
  logic         d_wr   = 1'b0;
  logic [1:0]   d_addr = 2'b00;
  logic [W-1:0] d_din  = '0;
  logic [W-1:0] d_pins = '0;

  // Reference model: pins are seen by the debouncer SS edges late; a channel
  // takes a new level once the last DC samples it saw all disagree with it.
  logic [W-1:0] m_pipe [$];
  logic [W-1:0] m_win  [$];
  logic [W-1:0] m_level, m_rise, m_fall, m_mask, m_wdata;
  logic         m_irq;

  task automatic model_reset();
    m_pipe.delete();
    m_win.delete();
    for (int k = 0; k < SS; k++) m_pipe.push_back('0);
    m_level = '0; m_rise = '0; m_fall = '0; m_mask = '0; m_wdata = '0; m_irq = 1'b0;
  endtask

  task automatic model_step();
    logic [W-1:0] seen, flip, clr_r, clr_f;
    bit           all_diff;
    if (d_rst) begin
      model_reset();
      return;
    end
    seen = m_pipe.pop_front();
    m_pipe.push_back(d_pins);
    m_win.push_back(seen);
    if (m_win.size() > DC) void'(m_win.pop_front());
    flip = '0;
    if (m_win.size() == DC) begin
      for (int i = 0; i < W; i++) begin
        all_diff = 1'b1;
        foreach (m_win[k]) if (m_win[k][i] == m_level[i]) all_diff = 1'b0;
        flip[i] = all_diff;
      end
    end
    clr_r = '0;
    clr_f = '0;
    m_irq = |((m_rise | m_fall) & m_mask);
    if (d_cs && d_rd) begin
      case (d_addr)
        2'd0: m_wdata = m_level;
        2'd1: begin m_wdata = m_rise; clr_r = m_rise; end
        2'd2: begin m_wdata = m_fall; clr_f = m_fall; end
        default: m_wdata = m_mask;
      endcase
    end
    m_rise  = (m_rise & ~clr_r) | (flip & ~m_level);
    m_fall  = (m_fall & ~clr_f) | (flip & m_level);
    m_level = m_level ^ flip;
    if (d_cs && d_wr && d_addr == 2'd3) m_mask = d_din;
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic tick();
    @(negedge switclk);
    switrst      = d_rst;
    switcs       = d_cs;
    switread     = d_rd;
    switwrite    = d_wr;
    switaddr     = d_addr;
    switch_din   = d_din;
    switch_rdata = d_pins;
    model_step();
    @(posedge switclk);
    #1;
    check("wdata", {16'h0, switch_wdata}, {16'h0, m_wdata});
    check("irq", {31'h0, switch_irq}, {31'h0, m_irq});
  endtask

  task automatic strobes_off();
    d_cs = 1'b0; d_rd = 1'b0; d_wr = 1'b0; d_addr = 2'd0;
  endtask

  logic [W-1:0] hold_exp;

  initial begin
    switrst = 1'b1; switcs = 1'b0; switread = 1'b0; switwrite = 1'b0;
    switaddr = 2'd0; switch_din = '0; switch_rdata = '0;
    model_reset();

    // Reset with all pins high, then re-debounce after release.
    d_pins = 16'hFFFF; d_rst = 1'b1;
    tick();
    check("rst_wdata", {16'h0, switch_wdata}, 32'h0);
    check("rst_irq", {31'h0, switch_irq}, 32'h0);
    tick();
    d_rst = 1'b0;
    repeat (SS + DC) tick();
    d_cs = 1'b1; d_rd = 1'b1; d_addr = 2'd0;
    tick();
    check("rst_level", {16'h0, switch_wdata}, 32'hFFFF);
    d_addr = 2'd1;
    tick();
    check("rst_rise", {16'h0, switch_wdata}, 32'hFFFF);
    d_addr = 2'd2;
    tick();
    strobes_off();

    // Glitch shorter than DC, then a real press on bits 0 and 2.
    d_pins = '0; d_rst = 1'b1;
    tick();
    d_rst = 1'b0;
    d_pins = 16'h0001;
    repeat (3) tick();
    d_pins = '0;
    repeat (8) tick();
    d_cs = 1'b1; d_rd = 1'b1; d_addr = 2'd0;
    tick();
    check("glitch_level", {16'h0, switch_wdata}, 32'h0);
    d_addr = 2'd1;
    tick();
    check("glitch_rise", {16'h0, switch_wdata}, 32'h0);
    d_addr = 2'd0;
    d_pins = 16'h0005;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == SS + DC) check("press_lvl_early", {16'h0, switch_wdata}, 32'h0);
      if (k == SS + DC + 1) check("press_lvl", {16'h0, switch_wdata}, 32'h0005);
    end

    // Clear-on-read.
    d_addr = 2'd1;
    tick();
    check("cor_first", {16'h0, switch_wdata}, 32'h0005);
    tick();
    check("cor_second", {16'h0, switch_wdata}, 32'h0);
    strobes_off();

    // Rise on bit 2 landing on the same edge as a rise-flag read.
    d_pins = 16'h0001;
    repeat (8) tick();
    d_cs = 1'b1; d_rd = 1'b1; d_addr = 2'd2;
    tick();
    strobes_off();
    d_pins = 16'h0005;
    for (int k = 1; k <= 8; k++) begin
      d_cs = (k >= SS + DC); d_rd = (k >= SS + DC); d_addr = 2'd1;
      tick();
      if (k == SS + DC) check("collide_old", {16'h0, switch_wdata}, 32'h0);
      if (k == SS + DC + 1) check("collide_kept", {16'h0, switch_wdata}, 32'h0004);
    end
    strobes_off();

    // Masked irq on bit 1 fall; unmasked bit 3 stays silent.
    d_pins = 16'h0007;
    repeat (8) tick();
    d_cs = 1'b1; d_rd = 1'b1; d_addr = 2'd1;
    tick();
    d_rd = 1'b0; d_wr = 1'b1; d_addr = 2'd3; d_din = 16'h0002;
    tick();
    strobes_off();
    tick();
    check("irq_idle", {31'h0, switch_irq}, 32'h0);
    d_pins = 16'h0005;
    for (int k = 1; k <= SS + DC + 1; k++) begin
      tick();
      if (k == SS + DC) check("irq_lag", {31'h0, switch_irq}, 32'h0);
      if (k == SS + DC + 1) check("irq_set", {31'h0, switch_irq}, 32'h1);
    end
    d_cs = 1'b1; d_rd = 1'b1; d_addr = 2'd2;
    tick();
    strobes_off();
    tick();
    check("irq_cleared", {31'h0, switch_irq}, 32'h0);
    d_pins = 16'h000D;
    repeat (10) tick();
    check("irq_unmasked", {31'h0, switch_irq}, 32'h0);

    // Strobes ignored without chip-select.
    hold_exp = m_wdata;
    d_cs = 1'b0; d_rd = 1'b1; d_addr = 2'd1;
    tick();
    check("cs_hold", {16'h0, switch_wdata}, {16'h0, hold_exp});
    d_cs = 1'b1;
    tick();
    check("cs_flags_kept", {16'h0, switch_wdata}, 32'h0008);
    strobes_off();

    // Reset in the middle of a debounce restarts the count.
    d_pins = 16'h001D;
    repeat (3) tick();
    d_rst = 1'b1;
    tick();
    d_rst = 1'b0;
    d_cs = 1'b1; d_rd = 1'b1; d_addr = 2'd0;
    for (int k = 1; k <= SS + DC + 1; k++) begin
      tick();
      if (k == SS + DC) check("rst_mid_early", {16'h0, switch_wdata}, 32'h0);
      if (k == SS + DC + 1) check("rst_mid_level", {16'h0, switch_wdata}, 32'h001D);
    end
    strobes_off();

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(3) == 0) d_pins = d_pins ^ (W'(1) << $urandom_range(W - 1));
      d_rst  = ($urandom_range(499) == 0);
      d_cs   = ($urandom_range(3) != 0);
      d_rd   = $urandom_range(1);
      d_wr   = ($urandom_range(7) == 0);
      d_addr = 2'($urandom_range(3));
      d_din  = W'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
